// File: rtl/uart_cmd_pkg.sv
// Shared types for the UART command wrapper.
//   rx_state_t : command assembly FSM (waiting for high byte / low byte)
//   tx_state_t : response transmit FSM (idle / byte in flight)
package uart_cmd_pkg;

  typedef enum logic {
    RX_HIGH = 1'b0,
    RX_LOW  = 1'b1
  } rx_state_t;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_BUSY = 1'b1
  } tx_state_t;

endpackage : uart_cmd_pkg

// File: rtl/uart_cmd_if.sv
// Command/response handshake bundle between the UART command wrapper and the
// logic that consumes commands and produces response bytes.
//   cmd[15:0]    assembled command {high, low}, valid while cmd_rdy=1
//   cmd_rdy      a new command is held in cmd
//   clr_cmd_rdy  consumer acknowledge (clears cmd_rdy and overrun)
//   overrun      sticky: a command completed while cmd_rdy was still set
//   frame_drop   one-cycle pulse when a dangling high byte is discarded
//   resp[7:0]    response byte, sampled on send_resp
//   send_resp    request transmission of resp
//   tx_busy      response transmission in progress
//   resp_sent    one-cycle pulse when the response byte has left TX
// slave  : the wrapper side
// master : the command consumer / response producer side
interface uart_cmd_if;

  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        overrun;
  logic        frame_drop;
  logic [7:0]  resp;
  logic        send_resp;
  logic        tx_busy;
  logic        resp_sent;

  modport slave (
    output cmd, cmd_rdy, overrun, frame_drop, tx_busy, resp_sent,
    input  clr_cmd_rdy, resp, send_resp
  );

  modport master (
    input  cmd, cmd_rdy, overrun, frame_drop, tx_busy, resp_sent,
    output clr_cmd_rdy, resp, send_resp
  );

endinterface : uart_cmd_if

// File: rtl/uart_cmd_uart.sv
// 8N1 UART transceiver, LSB first, BAUD_DIV clocks per bit.
//   i_rx        serial input (synchronised internally)
//   o_tx        serial output, idles high
//   o_rx_data   last received byte
//   o_rdy       byte available; held until i_clr_rdy, drops the cycle after
//   i_clr_rdy   consumer has taken o_rx_data
//   i_trmt      start transmitting i_tx_data (ignored while a frame is in flight)
//   i_tx_data   byte to transmit
//   o_tx_done   one-cycle pulse after the stop bit has been driven
module uart_cmd_uart #(
  parameter int BAUD_DIV = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_rx,
  output logic       o_tx,
  output logic [7:0] o_rx_data,
  output logic       o_rdy,
  input  logic       i_clr_rdy,
  input  logic       i_trmt,
  input  logic [7:0] i_tx_data,
  output logic       o_tx_done
);

  localparam int BW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam logic [BW-1:0] BAUD_FULL = BW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] BAUD_HALF = BW'(BAUD_DIV / 2 - 1);

  // ---------------- receiver ----------------
  logic          r_rx_s1;
  logic          r_rx_s2;
  logic          r_rx_busy;
  logic [BW-1:0] r_rx_baud;
  logic [3:0]    r_rx_bit;
  logic [7:0]    r_rx_shift;
  logic [7:0]    r_rx_data;
  logic          r_rdy;

  // Bit index 0 is the start bit, 1..8 data, 9 stop. The first wait is half
  // a bit so every later sample lands mid-bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_busy  <= 1'b0;
      r_rx_baud  <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
      r_rx_data  <= '0;
      r_rdy      <= 1'b0;
    end else begin
      r_rx_s1 <= i_rx;
      r_rx_s2 <= r_rx_s1;
      if (i_clr_rdy) r_rdy <= 1'b0;
      if (!r_rx_busy) begin
        if (!r_rx_s2) begin
          r_rx_busy <= 1'b1;
          r_rx_baud <= BAUD_HALF;
          r_rx_bit  <= '0;
        end
      end else if (r_rx_baud != '0) begin
        r_rx_baud <= r_rx_baud - BW'(1);
      end else begin
        r_rx_baud <= BAUD_FULL;
        r_rx_bit  <= r_rx_bit + 4'd1;
        if (r_rx_bit == 4'd0) begin
          // line back high at mid start bit: glitch, not a frame
          if (r_rx_s2) r_rx_busy <= 1'b0;
        end else if (r_rx_bit == 4'd9) begin
          r_rx_busy <= 1'b0;
          r_rx_data <= r_rx_shift;
          r_rdy     <= 1'b1;
        end else begin
          r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
        end
      end
    end
  end

  assign o_rx_data = r_rx_data;
  assign o_rdy     = r_rdy;

  // ---------------- transmitter ----------------
  logic          r_tx_busy;
  logic [BW-1:0] r_tx_baud;
  logic [3:0]    r_tx_bit;
  logic [9:0]    r_tx_shift;
  logic          r_tx_done;

  // Ones are shifted in behind the frame, so bit 0 rests high when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_busy  <= 1'b0;
      r_tx_baud  <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '1;
      r_tx_done  <= 1'b0;
    end else begin
      r_tx_done <= 1'b0;
      if (!r_tx_busy) begin
        if (i_trmt) begin
          r_tx_shift <= {1'b1, i_tx_data, 1'b0};
          r_tx_busy  <= 1'b1;
          r_tx_baud  <= BAUD_FULL;
          r_tx_bit   <= '0;
        end
      end else if (r_tx_baud != '0) begin
        r_tx_baud <= r_tx_baud - BW'(1);
      end else begin
        r_tx_baud  <= BAUD_FULL;
        r_tx_shift <= {1'b1, r_tx_shift[9:1]};
        if (r_tx_bit == 4'd9) begin
          r_tx_busy <= 1'b0;
          r_tx_done <= 1'b1;
        end else begin
          r_tx_bit <= r_tx_bit + 4'd1;
        end
      end
    end
  end

  assign o_tx      = r_tx_shift[0];
  assign o_tx_done = r_tx_done;

endmodule : uart_cmd_uart

// File: rtl/uart_cmd_wrapper.sv
// DUT-side end of the host serial command link.
// Two UART bytes (high first) form a 16-bit command presented on bus.cmd with
// a cmd_rdy / clr_cmd_rdy handshake; a response byte requested on send_resp
// is sent back on TX. A high byte with no low byte within TIMEOUT_CYCLES
// clocks is dropped (frame_drop pulse) so the link resynchronises.
//   clk, rst_n  clock, asynchronous active-low reset
//   RX, TX      serial lines to/from the host
//   bus         uart_cmd_if.slave handshake bundle
module uart_cmd_wrapper
  import uart_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 500000,
  parameter int BAUD_DIV       = 434
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  uart_cmd_if.slave   bus
);

  localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  logic [7:0] w_rx_byte;
  logic       w_rdy;
  logic       w_clr_rdy;
  logic       w_tx_done;
  logic       r_trmt;
  logic [7:0] r_resp;

  uart_cmd_uart #(
    .BAUD_DIV (BAUD_DIV)
  ) u_uart (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_rx      (RX),
    .o_tx      (TX),
    .o_rx_data (w_rx_byte),
    .o_rdy     (w_rdy),
    .i_clr_rdy (w_clr_rdy),
    .i_trmt    (r_trmt),
    .i_tx_data (r_resp),
    .o_tx_done (w_tx_done)
  );

  // ---------------- RX command assembly FSM ----------------
  rx_state_t        r_rx_state;
  rx_state_t        w_rx_next;
  logic [TMR_W-1:0] r_timer;
  logic [7:0]       r_high_byte;
  logic [15:0]      r_cmd;
  logic             r_cmd_rdy;
  logic             r_overrun;
  logic             w_tmo_hit;
  logic             w_latch_high;
  logic             w_cmd_done;
  logic             w_frame_drop;

  assign w_tmo_hit = (r_timer == TMO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rx_state <= RX_HIGH;
    else        r_rx_state <= w_rx_next;
  end

  // A byte arriving on the timeout cycle wins over the timeout.
  always_comb begin
    w_rx_next = r_rx_state;
    case (r_rx_state)
      RX_HIGH: if (w_rdy) w_rx_next = RX_LOW;
      RX_LOW:  if (w_rdy || w_tmo_hit) w_rx_next = RX_HIGH;
    endcase
  end

  always_comb begin
    w_clr_rdy    = 1'b0;
    w_latch_high = 1'b0;
    w_cmd_done   = 1'b0;
    w_frame_drop = 1'b0;
    case (r_rx_state)
      RX_HIGH: begin
        w_clr_rdy    = w_rdy;
        w_latch_high = w_rdy;
      end
      RX_LOW: begin
        w_clr_rdy    = w_rdy;
        w_cmd_done   = w_rdy;
        w_frame_drop = !w_rdy && w_tmo_hit;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer     <= '0;
      r_high_byte <= '0;
    end else begin
      if (w_latch_high) begin
        r_high_byte <= w_rx_byte;
        r_timer     <= '0;
      end else if (r_rx_state == RX_LOW) begin
        r_timer <= r_timer + TMR_W'(1);
      end
    end
  end

  // An acknowledge in the completion cycle refers to the previous command,
  // so the new one is still flagged ready and no overrun is recorded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd     <= '0;
      r_cmd_rdy <= 1'b0;
      r_overrun <= 1'b0;
    end else if (w_cmd_done) begin
      r_cmd     <= {r_high_byte, w_rx_byte};
      r_cmd_rdy <= 1'b1;
      r_overrun <= bus.clr_cmd_rdy ? 1'b0 : (r_overrun | r_cmd_rdy);
    end else if (bus.clr_cmd_rdy) begin
      r_cmd_rdy <= 1'b0;
      r_overrun <= 1'b0;
    end
  end

  // ---------------- TX response FSM ----------------
  tx_state_t r_tx_state;
  tx_state_t w_tx_next;
  logic      w_tx_start;
  logic      w_resp_sent;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_tx_state <= TX_IDLE;
    else        r_tx_state <= w_tx_next;
  end

  always_comb begin
    w_tx_next = r_tx_state;
    case (r_tx_state)
      TX_IDLE: if (bus.send_resp) w_tx_next = TX_BUSY;
      TX_BUSY: if (w_tx_done)     w_tx_next = TX_IDLE;
    endcase
  end

  // send_resp is only honoured in TX_IDLE, which also drops a request that
  // coincides with tx_done.
  always_comb begin
    w_tx_start  = 1'b0;
    w_resp_sent = 1'b0;
    case (r_tx_state)
      TX_IDLE: w_tx_start  = bus.send_resp;
      TX_BUSY: w_resp_sent = w_tx_done;
    endcase
  end

  // trmt is issued one cycle after the request so the uart sees the
  // already-latched byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resp <= '0;
      r_trmt <= 1'b0;
    end else begin
      r_trmt <= w_tx_start;
      if (w_tx_start) r_resp <= bus.resp;
    end
  end

  assign bus.cmd        = r_cmd;
  assign bus.cmd_rdy    = r_cmd_rdy;
  assign bus.overrun    = r_overrun;
  assign bus.frame_drop = w_frame_drop;
  assign bus.tx_busy    = (r_tx_state == TX_BUSY);
  assign bus.resp_sent  = w_resp_sent;

endmodule : uart_cmd_wrapper
